bcd2_down_timer: RTL and testbench
==================================

# bcd2_down_timer

Two-digit BCD down-counting timer: the counting-down counterpart of our mod-10 up counter, for countdown and time-out functions such as a 00–99 second display timer. A value is loaded, then the block decrements once per `tick` strobe while running. It flags `done` when it reaches 00 and, optionally, reloads itself. It sits between a prescaler that generates `tick` and a seven-segment/BCD display path that consumes `Tens`/`Ones`.

## Interface
- `WRAP`, default 0: 0 = stop at 00; 1 = auto-reload the last loaded value on the next tick after reaching 00.
- `clock` input 1: single clock; all state changes on its rising edge.
- `reset` input 1: asynchronous, active-low; forces the reset state immediately.
- `load` input 1: synchronous load of `load_val`; highest priority.
- `load_val` input 8: BCD value, tens in [7:4], ones in [3:0].
- `start` input 1: begin or resume counting.
- `pause` input 1: suspend counting.
- `tick` input 1: one-cycle decrement strobe; acted on only in RUN.
- `Tens` output 4: current tens digit, 0–9.
- `Ones` output 4: current ones digit, 0–9.
- `running` output 1: high while the state is RUN.
- `count_eq_0` output 1: combinational, `Tens==0 && Ones==0`.
- `done` output 1: registered one-cycle pulse when the count reaches 00.

## Operation
- States: IDLE, RUN, PAUSED, DONE. Reset state is IDLE with Tens=0, Ones=0, reload register=00, done=0, running=0.
- Load (any state): digits take `load_val`, and the reload register takes the same value. Any digit above 9 is clamped to 9. State goes to IDLE and `done` is 0 in that cycle. Load overrides start, pause and tick in the same cycle.
- IDLE:
  - `start` with count≠00 goes to RUN.
  - `start` with count==00 is ignored.
  - `tick` is ignored.
- RUN, checked in this priority order:
  - `pause` goes to PAUSED; a tick in the same cycle is ignored.
  - `tick` decrements the count.
  - `start` is ignored.
- Decrement rules:
  - If Ones>0, Ones is decremented.
  - Otherwise Ones=9 and Tens is decremented.
  - The BCD digits never hold A–F.
- Reaching 00 (decrement from 01):
  - `done` pulses high for the following cycle.
  - With WRAP=0 the state goes to DONE.
  - With WRAP=1 the state stays RUN; the next tick at 00 loads the reload register (no decrement), and counting continues from there.
  - WRAP=1 with a reload value of 00: the tick at 00 reloads 00 and `done` does not pulse again. The bench must cover this degenerate case.
- PAUSED:
  - `start` (with `pause` low) returns to RUN.
  - Ticks are ignored; the count is held.
- DONE:
  - Count holds 00 and ticks are ignored.
  - Only `load` or `reset` leaves DONE; `start` is ignored.

## Timing
- All outputs except `count_eq_0` are registered; they update on the edge where the qualifying input is sampled and are visible in the next cycle.
- Decrement latency is one cycle from the `tick` edge to the new Tens/Ones.
- `done` asserts in the same cycle that Tens/Ones first read 00 and lasts exactly one cycle.
- `running` falls in the same cycle that DONE or PAUSED is entered.
- Asynchronous reset mid-count clears everything immediately, including a `done` pulse in flight. Operation resumes on the first clock edge after `reset` rises.
- Back-to-back ticks on consecutive cycles decrement on every cycle; there is no minimum tick spacing.

## Test plan
- Reset then load 0x25, start, 25 ticks: the count passes 25→24…→20→19 (a tick at 20 gives 19), reaches 00 after tick 25, `done` high for one cycle, state DONE, `running`=0.
- Load 0x3C (invalid ones digit): the digits read 3/9; start and one tick gives 38.
- WRAP=1, load 0x02, start, 4 ticks: count goes 01, 00 (`done` pulse), 02, 01; `running` stays 1 throughout.
- Load 0x10, start, tick → 09, pause with a simultaneous tick: the count stays 09 and the state is PAUSED. Further ticks give no change. Start then tick gives 08.
- Load 0x00 then start: the state stays IDLE and `running`=0. In DONE, start has no effect; load 0x05 returns to IDLE with count 05.
- Load 0x50, start, 3 ticks (count 47), assert `reset` low asynchronously between edges: Tens/Ones read 0 and `running` reads 0 before the next edge.

Source files
------------

// File: rtl/bcd2_down_timer_if.sv
// Control and display bundle for the two-digit BCD countdown timer.
// Control inputs are single-cycle level strobes sampled on the rising clock edge; there is
// no valid/ready back-pressure, and every display output is valid in every cycle.
interface bcd2_down_timer_if;
    logic       load;
    logic [7:0] load_val;
    logic       start;
    logic       pause;
    logic       tick;
    logic [3:0] Tens;
    logic [3:0] Ones;
    logic       running;
    logic       count_eq_0;
    logic       done;
    logic [1:0] dbg_state;

    modport master (
        output load, load_val, start, pause, tick,
        input  Tens, Ones, running, count_eq_0, done, dbg_state
    );

    modport slave (
        input  load, load_val, start, pause, tick,
        output Tens, Ones, running, count_eq_0, done, dbg_state
    );
endinterface

// File: rtl/bcd2_down_timer.sv
// Two-digit BCD down counter with load, start/pause control, a done pulse at 00,
// and optional auto-reload of the last loaded value.
module bcd2_down_timer #(
    parameter bit WRAP = 1'b0
) (
    input  logic               clock,
    input  logic               reset,
    bcd2_down_timer_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] tens_q, tens_d;
    logic [3:0] ones_q, ones_d;
    logic [7:0] reload_q, reload_d;
    logic       done_q, done_d;
    logic       count_zero;
    logic       count_one;

    function automatic logic [3:0] clamp_digit(input logic [3:0] digit);
        return (digit > 4'd9) ? 4'd9 : digit;
    endfunction

    assign count_zero = (tens_q == 4'd0) && (ones_q == 4'd0);
    assign count_one  = (tens_q == 4'd0) && (ones_q == 4'd1);

    always_comb begin
        state_d  = state_q;
        tens_d   = tens_q;
        ones_d   = ones_q;
        reload_d = reload_q;
        done_d   = 1'b0;

        if (bus.load) begin
            tens_d   = clamp_digit(bus.load_val[7:4]);
            ones_d   = clamp_digit(bus.load_val[3:0]);
            reload_d = {clamp_digit(bus.load_val[7:4]), clamp_digit(bus.load_val[3:0])};
            state_d  = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start && !count_zero) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (bus.pause) begin
                        state_d = PAUSED;
                    end else if (bus.tick) begin
                        if (count_zero) begin
                            // Only reachable with WRAP: reload instead of decrementing.
                            // A 00 reload value lands here again without a done pulse.
                            if (WRAP) begin
                                tens_d = reload_q[7:4];
                                ones_d = reload_q[3:0];
                            end
                        end else begin
                            if (ones_q != 4'd0) begin
                                ones_d = ones_q - 4'd1;
                            end else begin
                                ones_d = 4'd9;
                                tens_d = tens_q - 4'd1;
                            end
                            if (count_one) begin
                                done_d = 1'b1;
                                if (!WRAP) begin
                                    state_d = DONE;
                                end
                            end
                        end
                    end
                end
                PAUSED: begin
                    if (bus.start && !bus.pause) begin
                        state_d = RUN;
                    end
                end
                DONE: begin
                    state_d = DONE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            tens_q   <= 4'd0;
            ones_q   <= 4'd0;
            reload_q <= 8'h00;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            tens_q   <= tens_d;
            ones_q   <= ones_d;
            reload_q <= reload_d;
            done_q   <= done_d;
        end
    end

    assign bus.Tens       = tens_q;
    assign bus.Ones       = ones_q;
    assign bus.running    = (state_q == RUN);
    assign bus.count_eq_0 = count_zero;
    assign bus.done       = done_q;
    assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_bcd2_down_timer.sv
// Directed self-checking bench for bcd2_down_timer: one stop-at-00 instance and one
// auto-reload instance sharing the clock and the asynchronous reset.
module tb_bcd2_down_timer;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RUN    = 2'd1;
    localparam logic [1:0] S_PAUSED = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic clock;
    logic reset;
    int   checks;
    int   errors;

    bcd2_down_timer_if bus0 ();
    bcd2_down_timer_if bus1 ();

    bcd2_down_timer #(.WRAP(1'b0)) dut0 (.clock(clock), .reset(reset), .bus(bus0.slave));
    bcd2_down_timer #(.WRAP(1'b1)) dut1 (.clock(clock), .reset(reset), .bus(bus1.slave));

    // Clock and reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Scoreboard helpers
    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected count is given in decimal; the bench splits it into BCD digits itself.
    task automatic chk_cnt0(input string tag, input int val);
        chk({tag, "_tens"}, {4'd0, bus0.Tens}, 8'(val / 10));
        chk({tag, "_ones"}, {4'd0, bus0.Ones}, 8'(val % 10));
    endtask

    task automatic chk_cnt1(input string tag, input int val);
        chk({tag, "_tens"}, {4'd0, bus1.Tens}, 8'(val / 10));
        chk({tag, "_ones"}, {4'd0, bus1.Ones}, 8'(val % 10));
    endtask

    // Drivers: inputs change 1 time unit after a rising edge, outputs are sampled there too.
    task automatic step();
        @(posedge clock);
        #1;
        bus0.load = 1'b0; bus0.start = 1'b0; bus0.pause = 1'b0; bus0.tick = 1'b0;
        bus1.load = 1'b0; bus1.start = 1'b0; bus1.pause = 1'b0; bus1.tick = 1'b0;
    endtask

    task automatic load0(input logic [7:0] val);
        bus0.load = 1'b1; bus0.load_val = val; step();
    endtask

    task automatic load1(input logic [7:0] val);
        bus1.load = 1'b1; bus1.load_val = val; step();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        bus0.load = 1'b0; bus0.load_val = 8'h00; bus0.start = 1'b0; bus0.pause = 1'b0; bus0.tick = 1'b0;
        bus1.load = 1'b0; bus1.load_val = 8'h00; bus1.start = 1'b0; bus1.pause = 1'b0; bus1.tick = 1'b0;
        #3;
        chk_cnt0("rst_cnt", 0);
        chk("rst_running", {7'd0, bus0.running}, 8'd0);
        chk("rst_done", {7'd0, bus0.done}, 8'd0);
        chk("rst_eq0", {7'd0, bus0.count_eq_0}, 8'd1);
        chk("rst_state", {6'd0, bus0.dbg_state}, {6'd0, S_IDLE});
        #4 reset = 1'b1;

        // Full countdown 25 -> 00 with back-to-back ticks
        load0(8'h25);
        chk_cnt0("load25", 25);
        chk("load25_state", {6'd0, bus0.dbg_state}, {6'd0, S_IDLE});
        bus0.start = 1'b1; step();
        chk("start25_running", {7'd0, bus0.running}, 8'd1);
        for (int i = 1; i <= 25; i++) begin
            bus0.tick = 1'b1; step();
            chk_cnt0($sformatf("cd_t%0d", i), 25 - i);
            chk($sformatf("cd_done_t%0d", i), {7'd0, bus0.done}, (i == 25) ? 8'd1 : 8'd0);
        end
        chk("cd_end_running", {7'd0, bus0.running}, 8'd0);
        chk("cd_end_state", {6'd0, bus0.dbg_state}, {6'd0, S_DONE});
        chk("cd_end_eq0", {7'd0, bus0.count_eq_0}, 8'd1);
        bus0.tick = 1'b1; step();
        chk("done_one_cycle", {7'd0, bus0.done}, 8'd0);
        chk_cnt0("done_hold", 0);

        // DONE ignores start; load leaves it
        bus0.start = 1'b1; step();
        chk("done_start_state", {6'd0, bus0.dbg_state}, {6'd0, S_DONE});
        chk("done_start_running", {7'd0, bus0.running}, 8'd0);
        load0(8'h05);
        chk_cnt0("done_load05", 5);
        chk("done_load05_state", {6'd0, bus0.dbg_state}, {6'd0, S_IDLE});

        // Invalid ones digit clamps to 9
        load0(8'h3C);
        chk_cnt0("clamp_3c", 39);
        bus0.start = 1'b1; step();
        bus0.tick = 1'b1; step();
        chk_cnt0("clamp_tick", 38);

        // Load overrides start and tick in the same cycle
        bus0.load = 1'b1; bus0.load_val = 8'h42; bus0.start = 1'b1; bus0.tick = 1'b1; step();
        chk_cnt0("load_prio_cnt", 42);
        chk("load_prio_state", {6'd0, bus0.dbg_state}, {6'd0, S_IDLE});

        // IDLE ignores tick
        bus0.tick = 1'b1; step();
        chk_cnt0("idle_tick", 42);

        // Pause with simultaneous tick, then resume
        load0(8'h10);
        bus0.start = 1'b1; step();
        bus0.tick = 1'b1; step();
        chk_cnt0("p_tick09", 9);
        bus0.pause = 1'b1; bus0.tick = 1'b1; step();
        chk_cnt0("p_pause_cnt", 9);
        chk("p_state", {6'd0, bus0.dbg_state}, {6'd0, S_PAUSED});
        chk("p_running", {7'd0, bus0.running}, 8'd0);
        bus0.tick = 1'b1; step();
        bus0.tick = 1'b1; step();
        chk_cnt0("p_hold", 9);
        bus0.start = 1'b1; bus0.pause = 1'b1; step();
        chk("p_start_with_pause", {6'd0, bus0.dbg_state}, {6'd0, S_PAUSED});
        bus0.start = 1'b1; step();
        chk("p_resume_running", {7'd0, bus0.running}, 8'd1);
        bus0.tick = 1'b1; step();
        chk_cnt0("p_tick08", 8);

        // Start at 00 is ignored
        load0(8'h00);
        bus0.start = 1'b1; step();
        chk("zero_start_state", {6'd0, bus0.dbg_state}, {6'd0, S_IDLE});
        chk("zero_start_running", {7'd0, bus0.running}, 8'd0);
        chk("zero_eq0", {7'd0, bus0.count_eq_0}, 8'd1);

        // Asynchronous reset mid-count, between edges
        load0(8'h50);
        bus0.start = 1'b1; step();
        for (int i = 0; i < 3; i++) begin
            bus0.tick = 1'b1; step();
        end
        chk_cnt0("ar_47", 47);
        chk("ar_eq0_before", {7'd0, bus0.count_eq_0}, 8'd0);
        #2 reset = 1'b0;
        #1;
        chk_cnt0("ar_cnt", 0);
        chk("ar_running", {7'd0, bus0.running}, 8'd0);
        #1 reset = 1'b1;
        step();
        chk("ar_state_after", {6'd0, bus0.dbg_state}, {6'd0, S_IDLE});

        // Reset kills a done pulse in flight
        load0(8'h01);
        bus0.start = 1'b1; step();
        bus0.tick = 1'b1; step();
        chk("inflight_done", {7'd0, bus0.done}, 8'd1);
        #2 reset = 1'b0;
        #1;
        chk("inflight_done_rst", {7'd0, bus0.done}, 8'd0);
        chk("inflight_state_rst", {6'd0, bus0.dbg_state}, {6'd0, S_IDLE});
        #1 reset = 1'b1;
        step();

        // WRAP=1: 02 -> 01 -> 00 (done) -> 02 -> 01, running throughout
        load1(8'h02);
        bus1.start = 1'b1; step();
        bus1.tick = 1'b1; step();
        chk_cnt1("w_t1", 1);
        chk("w_t1_done", {7'd0, bus1.done}, 8'd0);
        bus1.tick = 1'b1; step();
        chk_cnt1("w_t2", 0);
        chk("w_t2_done", {7'd0, bus1.done}, 8'd1);
        chk("w_t2_running", {7'd0, bus1.running}, 8'd1);
        bus1.tick = 1'b1; step();
        chk_cnt1("w_t3", 2);
        chk("w_t3_done", {7'd0, bus1.done}, 8'd0);
        chk("w_t3_running", {7'd0, bus1.running}, 8'd1);
        bus1.tick = 1'b1; step();
        chk_cnt1("w_t4", 1);
        chk("w_t4_running", {7'd0, bus1.running}, 8'd1);

        // WRAP=1 with reload 00: start is refused, ticks never produce a done pulse
        load1(8'h00);
        bus1.start = 1'b1; step();
        chk("w0_running", {7'd0, bus1.running}, 8'd0);
        for (int i = 0; i < 3; i++) begin
            bus1.tick = 1'b1; step();
            chk($sformatf("w0_done_%0d", i), {7'd0, bus1.done}, 8'd0);
            chk_cnt1($sformatf("w0_cnt_%0d", i), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
